// File: rtl/rpn_pkg.sv
// Shared constants and state encoding for the RPN stack master.
package rpn_pkg;

  localparam logic [1:0] KIND_OPND = 2'b00;
  localparam logic [1:0] KIND_OP   = 2'b01;
  localparam logic [1:0] KIND_END  = 2'b10;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_XOR = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    PUSH,
    POP_B,
    CAP_B,
    POP_A,
    CAP_A,
    POP_R,
    CAP_R
  } state_t;

endpackage

// File: rtl/rpn_stack_master_if.sv
// Token input, stack request/response and result signals of the RPN stack master.
interface rpn_stack_master_if #(
  parameter int DATA_W = 4
);
  logic              Tok_Valid;
  logic              Tok_Ready;
  logic [1:0]        Tok_Kind;
  logic [DATA_W-1:0] Tok_Data;
  logic              St_Push;
  logic              St_Pop;
  logic [DATA_W-1:0] St_Data_In;
  logic [DATA_W-1:0] St_Data_Out;
  logic              St_Full;
  logic              St_Empty;
  logic [DATA_W-1:0] Result;
  logic              Result_Valid;
  logic              Error;

  modport master (
    input  Tok_Valid, Tok_Kind, Tok_Data, St_Data_Out, St_Full, St_Empty,
    output Tok_Ready, St_Push, St_Pop, St_Data_In, Result, Result_Valid, Error
  );

  modport slave (
    output Tok_Valid, Tok_Kind, Tok_Data, St_Data_Out, St_Full, St_Empty,
    input  Tok_Ready, St_Push, St_Pop, St_Data_In, Result, Result_Valid, Error
  );
endinterface

// File: rtl/rpn_alu.sv
// Combinational operator unit: A op B, wrapping modulo 2^DATA_W.
// Zero latency; no flow control.
module rpn_alu
  import rpn_pkg::*;
#(
  parameter int DATA_W = 4
) (
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic [1:0]        i_op,
  output logic [DATA_W-1:0] o_y
);

  always_comb begin
    o_y = '0;
    case (i_op)
      OP_ADD:  o_y = i_a + i_b;
      OP_SUB:  o_y = i_a - i_b;
      OP_AND:  o_y = i_a & i_b;
      OP_XOR:  o_y = i_a ^ i_b;
      default: o_y = '0;
    endcase
  end

endmodule

// File: rtl/rpn_stack_master.sv
// RPN evaluator driving an external push/pop stack; one token in flight at a time.
// Operand 2 cycles, operator 6, end 3; Tok_Ready is high only while idle.
module rpn_stack_master
  import rpn_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 8
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  rpn_stack_master_if.master m_bus
);

  if (DEPTH < 2) begin : g_depth_chk
    $error("rpn_stack_master: DEPTH must be at least 2");
  end

  state_t            r_state;
  logic [1:0]        r_op;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic              r_tok_rdy;
  logic              r_push;
  logic              r_pop;
  logic [DATA_W-1:0] r_din;
  logic [DATA_W-1:0] r_result;
  logic              r_res_vld;
  logic              r_err;
  logic [DATA_W-1:0] w_alu_a;
  logic [DATA_W-1:0] w_alu;

  // A is forwarded straight from the stack in its capture cycle so the
  // push of f(A,B) can be registered one cycle later.
  assign w_alu_a = (r_state == CAP_A) ? m_bus.St_Data_Out : r_a;

  rpn_alu #(.DATA_W(DATA_W)) u_alu (
    .i_a  (w_alu_a),
    .i_b  (r_b),
    .i_op (r_op),
    .o_y  (w_alu)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= IDLE;
      r_op      <= OP_ADD;
      r_a       <= '0;
      r_b       <= '0;
      r_tok_rdy <= 1'b1;
      r_push    <= 1'b0;
      r_pop     <= 1'b0;
      r_din     <= '0;
      r_result  <= '0;
      r_res_vld <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_push    <= 1'b0;
      r_pop     <= 1'b0;
      r_res_vld <= 1'b0;
      case (r_state)
        IDLE: begin
          if (m_bus.Tok_Valid && r_tok_rdy) begin
            case (m_bus.Tok_Kind)
              KIND_OPND: begin
                if (m_bus.St_Full) begin
                  r_err <= 1'b1;
                end else begin
                  r_push    <= 1'b1;
                  r_din     <= m_bus.Tok_Data;
                  r_tok_rdy <= 1'b0;
                  r_state   <= PUSH;
                end
              end
              KIND_OP: begin
                r_op      <= m_bus.Tok_Data[1:0];
                r_pop     <= !m_bus.St_Empty;
                r_tok_rdy <= 1'b0;
                r_state   <= POP_B;
              end
              KIND_END: begin
                r_pop     <= !m_bus.St_Empty;
                r_tok_rdy <= 1'b0;
                r_state   <= POP_R;
              end
              default: ;
            endcase
          end
        end
        PUSH: begin
          r_tok_rdy <= 1'b1;
          r_state   <= IDLE;
        end
        POP_B: begin
          if (m_bus.St_Empty) begin
            r_err     <= 1'b1;
            r_tok_rdy <= 1'b1;
            r_state   <= IDLE;
          end else begin
            r_state <= CAP_B;
          end
        end
        CAP_B: begin
          r_b     <= m_bus.St_Data_Out;
          r_pop   <= !m_bus.St_Empty;
          r_state <= POP_A;
        end
        POP_A: begin
          if (m_bus.St_Empty) begin
            r_err     <= 1'b1;
            r_tok_rdy <= 1'b1;
            r_state   <= IDLE;
          end else begin
            r_state <= CAP_A;
          end
        end
        CAP_A: begin
          r_a     <= m_bus.St_Data_Out;
          r_push  <= 1'b1;
          r_din   <= w_alu;
          r_state <= PUSH;
        end
        POP_R: begin
          if (m_bus.St_Empty) begin
            r_err     <= 1'b1;
            r_tok_rdy <= 1'b1;
            r_state   <= IDLE;
          end else begin
            r_state <= CAP_R;
          end
        end
        CAP_R: begin
          r_result  <= m_bus.St_Data_Out;
          r_res_vld <= 1'b1;
          if (!m_bus.St_Empty) r_err <= 1'b1;
          r_tok_rdy <= 1'b1;
          r_state   <= IDLE;
        end
        default: begin
          r_tok_rdy <= 1'b1;
          r_state   <= IDLE;
        end
      endcase
    end
  end

  assign m_bus.Tok_Ready    = r_tok_rdy;
  assign m_bus.St_Push      = r_push;
  assign m_bus.St_Pop       = r_pop;
  assign m_bus.St_Data_In   = r_din;
  assign m_bus.Result       = r_result;
  assign m_bus.Result_Valid = r_res_vld;
  assign m_bus.Error        = r_err;

endmodule

// File: doc/rpn_stack_master.md
Name: rpn_stack_master

Overview:
Initiator for the 4-bit push/pop stack interface. Consumes a stream of Reverse-Polish tokens (operands, operators, end marker) and drives Push/Pop on an attached stack. It evaluates the expression using the stack as operand storage and reports the final value or an error. Sits between a token source, such as a keypad/decoder, and one stack instance.

Parameters:
DATA_W, 4, operand/result width; must equal stack data width
DEPTH, 8, stack capacity; informational only, capacity is sensed via St_Full

Ports:
Clk  input  1  system clock, rising edge
RstN  input  1  asynchronous active-low reset
Tok_Valid  input  1  token present
Tok_Ready  output  1  block can accept token this cycle
Tok_Kind  input  2  00 operand, 01 operator, 10 end, 11 reserved
Tok_Data  input  DATA_W  operand value; operator code in [1:0]
St_Push  output  1  push request to stack
St_Pop  output  1  pop request to stack
St_Data_In  output  DATA_W  value to push
St_Data_Out  input  DATA_W  popped value, valid the cycle after St_Pop
St_Full  input  1  stack holds DEPTH entries
St_Empty  input  1  stack holds zero entries (high = empty)
Result  output  DATA_W  final value, held until next Result_Valid
Result_Valid  output  1  one-cycle pulse with new Result
Error  output  1  sticky: underflow, overflow or leftover entries

Behaviour:
- Interface: one clock, Clk; reset is asynchronous and active-low (RstN).
- Reset: state IDLE. Tok_Ready=1. St_Push=St_Pop=0. St_Data_In=0, Result=0, Result_Valid=0, Error=0. Internal A/B regs 0.
- Reset mid-operation aborts immediately. Stack contents are the stack's own concern.
- All outputs are registered. St_Push and St_Pop are never high together. Each is high for at most 1 cycle per request.
- Handshake: token transfers when Tok_Valid && Tok_Ready. Tok_Ready=1 only in IDLE.
- States: IDLE, PUSH, POP_B, CAP_B, POP_A, CAP_A, POP_R, CAP_R.
- Operand (accepted cycle 0):
  - St_Full=1: set Error, token dropped, stay IDLE.
  - Otherwise: PUSH with St_Push=1 and St_Data_In=Tok_Data in cycle 1; IDLE in cycle 2.
- Operator (accepted cycle 0):
  - Cycle 1, POP_B: if St_Empty, set Error and return to IDLE with no pop. Else St_Pop=1.
  - Cycle 2, CAP_B: B<=St_Data_Out.
  - Cycle 3, POP_A: if St_Empty, set Error and return to IDLE; B is discarded. Else St_Pop=1.
  - Cycle 4, CAP_A: A<=St_Data_Out.
  - Cycle 5, PUSH: St_Push=1 with f(A,B). Back to IDLE in cycle 6.
  - Op codes: 00 A+B, 01 A-B, 10 A&B, 11 A^B. Results are modulo 2^DATA_W; carry/borrow is discarded, no flag.
  - Total: 6 cycles per operator.
- End (accepted cycle 0):
  - Cycle 1, POP_R: if St_Empty, set Error and return to IDLE with no Result_Valid. Else St_Pop=1.
  - Cycle 2, CAP_R: Result<=St_Data_Out.
  - Cycle 3: Result_Valid=1. If St_Empty=0 (leftover entries), set Error; leftovers are not drained.
- Reserved kind: accepted and dropped, no stack activity.
- Error: sticky; cleared only by reset. Processing continues while it is set.
- Simultaneous events: none are possible, since a single token is in flight at a time.

Decomposition:
- Package rpn_pkg:
  - Token kind constants: KIND_OPND, KIND_OP, KIND_END.
  - Op codes: OP_ADD, OP_SUB, OP_AND, OP_XOR.
  - State encoding enum.
- One sub-module, rpn_alu: combinational A,B,op -> DATA_W result.
- Bench pairs this block with a behavioural stack model: depth 8, registered Data_Out, St_Empty high when empty.

Test Plan:
- Tokens 3,4,ADD,END -> pushes 3 and 4; pops 4 then 3; pushes 7; Result=7 with one Result_Valid pulse; Error=0; operator takes exactly 6 cycles.
- Tokens 2,5,SUB,END -> Result=13 (2-5 mod 16), Error=0.
- Tokens 9 then ADD -> Error=1 at the POP_A check; exactly one St_Pop issued; back to IDLE with Tok_Ready=1.
- Nine operands, stack full after 8 -> ninth operand produces no St_Push and Error=1. A following END gives Result=last pushed value, and Error stays 1 (leftover).
- Tokens 12,10,AND,6,XOR,END -> Result=14. RstN pulsed low mid-operator on a second run -> all outputs at reset values at once, Tok_Ready=1.
